// File: rtl/icache_victim_swap_controller.sv
// L1 I-cache miss controller: probes the victim cache, falls back to L2, swaps
// the displaced L1 line into the victim cache, then pulses the refill back to L1.
// Optional hit/miss statistics counters are enabled by defining VICTIM_STATS_EN.
module icache_victim_swap_controller #(
   parameter int unsigned BLOCK_WIDTH    = 512,
   parameter int unsigned TAG_WIDTH      = 26,
   parameter int unsigned VICTIM_LATENCY = 2
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   MISS_REQ,
   input  logic [TAG_WIDTH-1:0]   MISS_TAG,
   input  logic                   EVICT_VALID,
   input  logic [TAG_WIDTH-1:0]   EVICT_TAG,
   input  logic [BLOCK_WIDTH-1:0] EVICT_DATA,
   output logic                   MISS_BUSY,
   output logic                   REFILL_VALID,
   output logic [TAG_WIDTH-1:0]   REFILL_TAG,
   output logic [BLOCK_WIDTH-1:0] REFILL_DATA,
   output logic                   REFILL_SRC,
   output logic [TAG_WIDTH-1:0]   VC_READ_TAG_ADDRESS,
   output logic                   VC_READ_ENBLE,
   input  logic                   VC_READ_HIT,
   input  logic [BLOCK_WIDTH-1:0] VC_READ_DATA,
   output logic [TAG_WIDTH-1:0]   VC_WRITE_TAG_ADDRESS,
   output logic [BLOCK_WIDTH-1:0] VC_WRITE_DATA,
   output logic                   VC_WRITE_ENABLE,
   output logic                   L2_REQ_VALID,
   output logic [TAG_WIDTH-1:0]   L2_REQ_TAG,
   input  logic                   L2_REQ_READY,
   input  logic                   L2_RESP_VALID,
   input  logic [BLOCK_WIDTH-1:0] L2_RESP_DATA
`ifdef VICTIM_STATS_EN
   ,
   output logic [31:0]            STAT_VC_HITS,
   output logic [31:0]            STAT_VC_MISSES
`endif
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PROBE,
      S_EVAL,
      S_L2_REQ,
      S_L2_WAIT,
      S_EVICT_WR,
      S_REFILL
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       probe_cnt;
   logic [TAG_WIDTH-1:0]   miss_tag_q;
   logic                   evict_valid_q;
   logic [TAG_WIDTH-1:0]   evict_tag_q;
   logic [BLOCK_WIDTH-1:0] evict_data_q;
   logic [BLOCK_WIDTH-1:0] blk_q;
   logic                   src_q;

   // Miss sequencing FSM; every output is set on the transition into the state that owns it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state                <= S_IDLE;
         probe_cnt            <= '0;
         miss_tag_q           <= '0;
         evict_valid_q        <= 1'b0;
         evict_tag_q          <= '0;
         evict_data_q         <= '0;
         blk_q                <= '0;
         src_q                <= 1'b0;
         MISS_BUSY            <= 1'b0;
         REFILL_VALID         <= 1'b0;
         REFILL_TAG           <= '0;
         REFILL_DATA          <= '0;
         REFILL_SRC           <= 1'b0;
         VC_READ_TAG_ADDRESS  <= '0;
         VC_READ_ENBLE        <= 1'b0;
         VC_WRITE_TAG_ADDRESS <= '0;
         VC_WRITE_DATA        <= '0;
         VC_WRITE_ENABLE      <= 1'b0;
         L2_REQ_VALID         <= 1'b0;
         L2_REQ_TAG           <= '0;
      end else begin
         REFILL_VALID    <= 1'b0;
         VC_WRITE_ENABLE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (MISS_REQ) begin
                  miss_tag_q          <= MISS_TAG;
                  evict_valid_q       <= EVICT_VALID;
                  evict_tag_q         <= EVICT_TAG;
                  evict_data_q        <= EVICT_DATA;
                  probe_cnt           <= CNT_W'(VICTIM_LATENCY - 1);
                  VC_READ_ENBLE       <= 1'b1;
                  VC_READ_TAG_ADDRESS <= MISS_TAG;
                  MISS_BUSY           <= 1'b1;
                  state               <= S_PROBE;
               end
            end
            S_PROBE: begin
               if (probe_cnt == CNT_W'(0)) begin
                  VC_READ_ENBLE <= 1'b0;
                  state         <= S_EVAL;
               end else begin
                  probe_cnt <= probe_cnt - CNT_W'(1);
               end
            end
            S_EVAL: begin
               if (VC_READ_HIT) begin
                  blk_q           <= VC_READ_DATA;
                  src_q           <= 1'b1;
                  VC_WRITE_ENABLE <= evict_valid_q;
                  if (evict_valid_q) begin
                     VC_WRITE_TAG_ADDRESS <= evict_tag_q;
                     VC_WRITE_DATA        <= evict_data_q;
                  end
                  state <= S_EVICT_WR;
               end else begin
                  L2_REQ_VALID <= 1'b1;
                  L2_REQ_TAG   <= miss_tag_q;
                  state        <= S_L2_REQ;
               end
            end
            S_L2_REQ: begin
               if (L2_REQ_READY) begin
                  L2_REQ_VALID <= 1'b0;
                  state        <= S_L2_WAIT;
               end
            end
            S_L2_WAIT: begin
               if (L2_RESP_VALID) begin
                  blk_q           <= L2_RESP_DATA;
                  src_q           <= 1'b0;
                  VC_WRITE_ENABLE <= evict_valid_q;
                  if (evict_valid_q) begin
                     VC_WRITE_TAG_ADDRESS <= evict_tag_q;
                     VC_WRITE_DATA        <= evict_data_q;
                  end
                  state <= S_EVICT_WR;
               end
            end
            S_EVICT_WR: begin
               REFILL_VALID <= 1'b1;
               REFILL_TAG   <= miss_tag_q;
               REFILL_DATA  <= blk_q;
               REFILL_SRC   <= src_q;
               state        <= S_REFILL;
            end
            S_REFILL: begin
               MISS_BUSY <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef VICTIM_STATS_EN
   // Saturating victim hit/miss counters, updated in the probe evaluation cycle.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         STAT_VC_HITS   <= '0;
         STAT_VC_MISSES <= '0;
      end else if (state == S_EVAL) begin
         if (VC_READ_HIT) begin
            if (STAT_VC_HITS != 32'hFFFF_FFFF) STAT_VC_HITS <= STAT_VC_HITS + 32'd1;
         end else begin
            if (STAT_VC_MISSES != 32'hFFFF_FFFF) STAT_VC_MISSES <= STAT_VC_MISSES + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_victim_swap_controller.sv
// Scoreboard bench for icache_victim_swap_controller: the driver predicts refills
// and victim writes from the miss/swap rules, a negedge monitor checks them.
module tb_icache_victim_swap_controller;

   localparam int unsigned BW  = 512;
   localparam int unsigned TW  = 26;
   localparam int unsigned VL  = 2;
   localparam int          BIG = 1 << 30;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          MISS_REQ = 1'b0;
   logic [TW-1:0] MISS_TAG = '0;
   logic          EVICT_VALID = 1'b0;
   logic [TW-1:0] EVICT_TAG = '0;
   logic [BW-1:0] EVICT_DATA = '0;
   logic          MISS_BUSY;
   logic          REFILL_VALID;
   logic [TW-1:0] REFILL_TAG;
   logic [BW-1:0] REFILL_DATA;
   logic          REFILL_SRC;
   logic [TW-1:0] VC_READ_TAG_ADDRESS;
   logic          VC_READ_ENBLE;
   logic          VC_READ_HIT = 1'b0;
   logic [BW-1:0] VC_READ_DATA = '0;
   logic [TW-1:0] VC_WRITE_TAG_ADDRESS;
   logic [BW-1:0] VC_WRITE_DATA;
   logic          VC_WRITE_ENABLE;
   logic          L2_REQ_VALID;
   logic [TW-1:0] L2_REQ_TAG;
   logic          L2_REQ_READY = 1'b0;
   logic          L2_RESP_VALID = 1'b0;
   logic [BW-1:0] L2_RESP_DATA = '0;
`ifdef VICTIM_STATS_EN
   logic [31:0]   STAT_VC_HITS;
   logic [31:0]   STAT_VC_MISSES;
`endif

   icache_victim_swap_controller #(
      .BLOCK_WIDTH(BW), .TAG_WIDTH(TW), .VICTIM_LATENCY(VL)
   ) dut (
      .CLK(CLK), .RSTN(RSTN),
      .MISS_REQ(MISS_REQ), .MISS_TAG(MISS_TAG),
      .EVICT_VALID(EVICT_VALID), .EVICT_TAG(EVICT_TAG), .EVICT_DATA(EVICT_DATA),
      .MISS_BUSY(MISS_BUSY),
      .REFILL_VALID(REFILL_VALID), .REFILL_TAG(REFILL_TAG),
      .REFILL_DATA(REFILL_DATA), .REFILL_SRC(REFILL_SRC),
      .VC_READ_TAG_ADDRESS(VC_READ_TAG_ADDRESS), .VC_READ_ENBLE(VC_READ_ENBLE),
      .VC_READ_HIT(VC_READ_HIT), .VC_READ_DATA(VC_READ_DATA),
      .VC_WRITE_TAG_ADDRESS(VC_WRITE_TAG_ADDRESS), .VC_WRITE_DATA(VC_WRITE_DATA),
      .VC_WRITE_ENABLE(VC_WRITE_ENABLE),
      .L2_REQ_VALID(L2_REQ_VALID), .L2_REQ_TAG(L2_REQ_TAG),
      .L2_REQ_READY(L2_REQ_READY),
      .L2_RESP_VALID(L2_RESP_VALID), .L2_RESP_DATA(L2_RESP_DATA)
`ifdef VICTIM_STATS_EN
      ,
      .STAT_VC_HITS(STAT_VC_HITS), .STAT_VC_MISSES(STAT_VC_MISSES)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [TW-1:0] tag;
      logic [BW-1:0] data;
      logic          src;
      int            at;
   } refill_t;

   typedef struct {
      logic [TW-1:0] tag;
      logic [BW-1:0] data;
      int            at;
   } wr_t;

   refill_t       rq[$];
   wr_t           wq[$];
   int            checks = 0;
   int            errors = 0;
   int            busy_from = BIG;
   int            busy_to = 0;
   int            rd_from = BIG;
   int            rd_to = 0;
   logic [TW-1:0] cur_tag = '0;
   logic          cur_hit = 1'b0;
   int            model_hits = 0;
   int            model_misses = 0;

   task automatic chk(input bit ok, input string name, input logic [BW-1:0] act,
                      input logic [BW-1:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] rnd_blk();
      logic [BW-1:0] r;
      for (int i = 0; i < int'(BW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: pops predictions when the DUT presents refills or victim writes.
   always @(negedge CLK) begin : mon
      refill_t r;
      wr_t     w;
      logic    eb;
      logic    er;
      if (RSTN) begin
         eb = (cyc >= busy_from) && (cyc <= busy_to);
         er = (cyc >= rd_from) && (cyc <= rd_to);
         chk(MISS_BUSY == eb, "miss_busy", BW'(MISS_BUSY), BW'(eb));
         chk(VC_READ_ENBLE == er, "vc_read_enable", BW'(VC_READ_ENBLE), BW'(er));
         if (VC_READ_ENBLE)
            chk(VC_READ_TAG_ADDRESS == cur_tag, "vc_read_tag", BW'(VC_READ_TAG_ADDRESS), BW'(cur_tag));
         if (VC_READ_ENBLE || VC_WRITE_ENABLE)
            chk(!(VC_READ_ENBLE && VC_WRITE_ENABLE), "vc_rd_wr_overlap",
                BW'({VC_READ_ENBLE, VC_WRITE_ENABLE}), BW'(0));
         if (L2_REQ_VALID) begin
            chk(!cur_hit, "l2_req_on_hit", BW'(L2_REQ_VALID), BW'(0));
            chk(L2_REQ_TAG == cur_tag, "l2_req_tag", BW'(L2_REQ_TAG), BW'(cur_tag));
         end
         while (rq.size() > 0 && rq[0].at < cyc) begin
            r = rq.pop_front();
            chk(1'b0, "refill_missing", BW'(0), BW'(r.at));
         end
         while (wq.size() > 0 && wq[0].at < cyc) begin
            w = wq.pop_front();
            chk(1'b0, "vc_write_missing", BW'(0), BW'(w.at));
         end
         if (REFILL_VALID) begin
            if (rq.size() == 0) begin
               chk(1'b0, "refill_unexpected", BW'(REFILL_TAG), BW'(0));
            end else begin
               r = rq.pop_front();
               chk(cyc == r.at, "refill_cycle", BW'(cyc), BW'(r.at));
               chk(REFILL_TAG == r.tag, "refill_tag", BW'(REFILL_TAG), BW'(r.tag));
               chk(REFILL_DATA == r.data, "refill_data", REFILL_DATA, r.data);
               chk(REFILL_SRC == r.src, "refill_src", BW'(REFILL_SRC), BW'(r.src));
            end
         end
         if (VC_WRITE_ENABLE) begin
            if (wq.size() == 0) begin
               chk(1'b0, "vc_write_unexpected", BW'(VC_WRITE_TAG_ADDRESS), BW'(0));
            end else begin
               w = wq.pop_front();
               chk(cyc == w.at, "vc_write_cycle", BW'(cyc), BW'(w.at));
               chk(VC_WRITE_TAG_ADDRESS == w.tag, "vc_write_tag", BW'(VC_WRITE_TAG_ADDRESS), BW'(w.tag));
               chk(VC_WRITE_DATA == w.data, "vc_write_data", VC_WRITE_DATA, w.data);
            end
         end
      end
   end

   task automatic check_all_zero(input string name);
      chk({MISS_BUSY, REFILL_VALID, REFILL_SRC, VC_READ_ENBLE, VC_WRITE_ENABLE, L2_REQ_VALID} == 6'b0,
          {name, "_ctl"}, BW'({MISS_BUSY, REFILL_VALID, REFILL_SRC, VC_READ_ENBLE, VC_WRITE_ENABLE, L2_REQ_VALID}), BW'(0));
      chk({REFILL_TAG, VC_READ_TAG_ADDRESS, VC_WRITE_TAG_ADDRESS, L2_REQ_TAG} == '0, {name, "_tags"},
          BW'({REFILL_TAG, VC_READ_TAG_ADDRESS, VC_WRITE_TAG_ADDRESS, L2_REQ_TAG}), BW'(0));
      chk(REFILL_DATA == '0, {name, "_refill_data"}, REFILL_DATA, BW'(0));
      chk(VC_WRITE_DATA == '0, {name, "_vc_write_data"}, VC_WRITE_DATA, BW'(0));
`ifdef VICTIM_STATS_EN
      chk(STAT_VC_HITS == 32'd0 && STAT_VC_MISSES == 32'd0, {name, "_stats"},
          BW'({STAT_VC_HITS, STAT_VC_MISSES}), BW'(0));
`endif
   endtask

   task automatic check_stats(input string name);
`ifdef VICTIM_STATS_EN
      chk(STAT_VC_HITS == 32'(model_hits), {name, "_hits"}, BW'(STAT_VC_HITS), BW'(model_hits));
      chk(STAT_VC_MISSES == 32'(model_misses), {name, "_misses"}, BW'(STAT_VC_MISSES), BW'(model_misses));
`else
      chk(rq.size() == 0, {name, "_refills_drained"}, BW'(rq.size()), BW'(0));
`endif
   endtask

   // Busy-time noise: MISS_REQ pulses and stray L2 responses that must be ignored.
   task automatic noise_cycle(input bit noise, input bit allow_resp);
      MISS_REQ      = noise ? 1'($urandom) : 1'b0;
      MISS_TAG      = TW'($urandom);
      L2_RESP_VALID = (noise && allow_resp) ? 1'($urandom) : 1'b0;
      L2_RESP_DATA  = rnd_blk();
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         MISS_REQ      = 1'b0;
         L2_RESP_VALID = 1'($urandom);
         L2_RESP_DATA  = rnd_blk();
      end
      @(posedge CLK); #1;
      L2_RESP_VALID = 1'b0;
   endtask

   task automatic do_txn(input bit hit, input logic [TW-1:0] mtag, input logic [BW-1:0] vdata,
                         input bit ev, input logic [TW-1:0] etag, input logic [BW-1:0] edata,
                         input logic [BW-1:0] l2data, input int rdy_dly, input int rsp_dly,
                         input bit noise, input bit do_reset);
      int n;
      int s;
      int k;
      @(posedge CLK); #1;
      MISS_REQ      = 1'b1;
      MISS_TAG      = mtag;
      EVICT_VALID   = ev;
      EVICT_TAG     = etag;
      EVICT_DATA    = edata;
      VC_READ_HIT   = hit;
      VC_READ_DATA  = vdata;
      L2_RESP_VALID = 1'b0;
      n         = cyc;
      cur_tag   = mtag;
      cur_hit   = hit;
      busy_from = n + 1;
      busy_to   = BIG;
      rd_from   = n + 1;
      rd_to     = n + int'(VL);
      if (hit) begin
         model_hits++;
         rq.push_back('{tag: mtag, data: vdata, src: 1'b1, at: n + int'(VL) + 3});
         if (ev) wq.push_back('{tag: etag, data: edata, at: n + int'(VL) + 2});
         busy_to = n + int'(VL) + 3;
         while (cyc < n + int'(VL) + 3) begin
            @(posedge CLK); #1;
            noise_cycle(noise, 1'b1);
         end
      end else begin
         model_misses++;
         k = 0;
         do begin
            @(posedge CLK); #1;
            noise_cycle(noise, 1'b1);
            k++;
         end while (!L2_REQ_VALID && k < 50);
         chk(cyc == n + int'(VL) + 2, "l2_req_latency", BW'(cyc), BW'(n + int'(VL) + 2));
         if (!L2_REQ_VALID) return;
         for (int i = 0; i < rdy_dly; i++) begin
            L2_REQ_READY = 1'b0;
            @(posedge CLK); #1;
            noise_cycle(noise, 1'b1);
            chk(L2_REQ_VALID, "l2_req_held", BW'(L2_REQ_VALID), BW'(1));
         end
         L2_REQ_READY  = 1'b1;
         L2_RESP_VALID = 1'b0;
         MISS_REQ      = 1'b0;
         @(posedge CLK); #1;
         L2_REQ_READY = 1'b0;
         chk(!L2_REQ_VALID, "l2_req_drop", BW'(L2_REQ_VALID), BW'(0));
         if (do_reset) begin
            RSTN = 1'b0;
            #1;
            check_all_zero("reset_in_l2_wait");
            busy_from = BIG; busy_to = 0; rd_from = BIG; rd_to = 0;
            model_hits = 0; model_misses = 0;
            @(posedge CLK); #1;
            RSTN = 1'b1;
            for (int i = 0; i < 3; i++) begin
               L2_RESP_VALID = 1'b1;
               L2_RESP_DATA  = rnd_blk();
               @(posedge CLK); #1;
            end
            L2_RESP_VALID = 1'b0;
            repeat (4) @(posedge CLK);
            #1;
            chk(!MISS_BUSY, "busy_after_reset", BW'(MISS_BUSY), BW'(0));
            return;
         end
         for (int i = 0; i < rsp_dly; i++) begin
            noise_cycle(noise, 1'b0);
            @(posedge CLK); #1;
         end
         s = cyc;
         L2_RESP_VALID = 1'b1;
         L2_RESP_DATA  = l2data;
         MISS_REQ      = 1'b0;
         rq.push_back('{tag: mtag, data: l2data, src: 1'b0, at: s + 2});
         if (ev) wq.push_back('{tag: etag, data: edata, at: s + 1});
         busy_to = s + 2;
         for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            noise_cycle(noise, 1'b1);
         end
      end
      MISS_REQ      = 1'b0;
      L2_RESP_VALID = 1'b0;
   endtask

   task automatic rand_txn(input bit noise);
      logic [TW-1:0] mt;
      logic [TW-1:0] et;
      mt = TW'($urandom);
      et = ($urandom_range(0, 3) == 0) ? mt : TW'($urandom);
      do_txn(1'($urandom), mt, rnd_blk(), 1'($urandom), et, rnd_blk(), rnd_blk(),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), noise, 1'b0);
      idle_gap(int'($urandom_range(0, 3)));
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("reset");
      RSTN = 1'b1;
      idle_gap(2);

      do_txn(1'b1, TW'(26'h0ABC), {64{8'hA5}}, 1'b1, TW'(26'h0123), rnd_blk(), '0, 0, 0, 1'b0, 1'b0);
      idle_gap(1);
      do_txn(1'b1, TW'($urandom), rnd_blk(), 1'b1, TW'($urandom), rnd_blk(), '0, 0, 0, 1'b1, 1'b0);
      idle_gap(1);
      do_txn(1'b1, TW'($urandom), rnd_blk(), 1'b0, TW'($urandom), rnd_blk(), '0, 0, 0, 1'b0, 1'b0);
      idle_gap(2);
      do_txn(1'b0, TW'(26'h0DEF), '0, 1'b1, TW'(26'h0456), rnd_blk(), {64{8'h5A}}, 3, 4, 1'b0, 1'b0);
      idle_gap(1);
      do_txn(1'b0, TW'($urandom), '0, 1'b0, TW'($urandom), rnd_blk(), rnd_blk(), 0, 0, 1'b1, 1'b0);
      idle_gap(2);
      check_stats("stats_3h_2m");

      for (int i = 0; i < 40; i++) rand_txn(1'b1);

      do_txn(1'b0, TW'($urandom), '0, 1'b1, TW'($urandom), rnd_blk(), rnd_blk(), 2, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) rand_txn(1'b1);

      repeat (4) @(posedge CLK);
      #1;
      check_stats("stats_final");
      chk(rq.size() == 0 && wq.size() == 0, "queues_drained", BW'({rq.size(), wq.size()}), BW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
